// File: rtl/expr_pkg.sv
// rtl/expr_pkg.sv - field layout constants, layout functions and FSM state type for the expression result unpacker
//
// Purpose: the packed word holds 18 fields {y0..y17}, y0 at the MSBs. Field i is
//          4 + (i % 3) bits wide and signed when (i / 3) is odd. Every group of
//          three fields spans 15 bits.
// Ports:   none (package)
// Config:  none here; the checksum beat is selected by EXPR_UNPACK_CHECKSUM_EN in the top.

package expr_pkg;

  localparam int unsigned EXPR_Y_W        = 90;
  localparam int unsigned EXPR_NUM_FIELDS = 18;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } expr_state_t;

  function automatic int unsigned field_w(input int unsigned i);
    return 4 + (i % 3);
  endfunction

  // Bits above field i are whole 15-bit groups plus the narrower siblings
  // that precede it inside its own group (0, 4 or 4+5 bits).
  function automatic int unsigned field_lsb(input int unsigned i);
    int unsigned above;
    above = 15 * (i / 3) + ((i % 3 == 0) ? 0 : ((i % 3 == 1) ? 4 : 9));
    return EXPR_Y_W - above - field_w(i);
  endfunction

  function automatic bit field_signed(input int unsigned i);
    return ((i / 3) % 2) == 1;
  endfunction

endpackage

// File: rtl/expr_field_extract.sv
// rtl/expr_field_extract.sv - combinational selection and extension of one field of the packed word
//
// Purpose: picks field idx out of the holding register and sign- or zero-extends
//          it to OUT_W bits. idx values outside 0..17 yield zero.
// Ports:   hold [89:0]      holding register contents
//          idx  [4:0]       field index
//          ext  [OUT_W-1:0] extended field value
// Config:  none.

module expr_field_extract
  import expr_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic [EXPR_Y_W-1:0] hold,
  input  logic [4:0]          idx,
  output logic [OUT_W-1:0]    ext
);

  logic [5:0] mask;
  logic [5:0] raw;
  logic       neg;

  always_comb begin
    mask = '0;
    raw  = '0;
    neg  = 1'b0;
    ext  = '0;
    if (32'(idx) < EXPR_NUM_FIELDS) begin
      mask = 6'((32'd1 << field_w(32'(idx))) - 32'd1);
      raw  = 6'(hold >> field_lsb(32'(idx))) & mask;
      neg  = field_signed(32'(idx)) && raw[3'(field_w(32'(idx)) - 1)];
      ext  = OUT_W'(raw);
      // Negative signed field: fill every bit above the field width with ones.
      if (neg) begin
        ext = ext | ~OUT_W'(mask);
      end
    end
  end

endmodule

// File: rtl/expr_result_unpacker.sv
// rtl/expr_result_unpacker.sv - streams the 18 fields of a packed expression result, one extended field per beat
//
// Purpose: accepts a 90-bit packed word in IDLE, then emits fields 0..17 over a
//          valid/ready stream, one per handshake, with out_last on the final beat.
// Ports:   clk, rst (async, active-high)
//          in_valid/in_ready/in_data[89:0]   packed word input
//          out_valid/out_ready/out_data[OUT_W-1:0]/out_idx[4:0]/out_last   field stream
// Config:  EXPR_UNPACK_CHECKSUM_EN adds a beat with out_idx 18 carrying the sum,
//          modulo 2^OUT_W, of the 18 extended field values.

module expr_result_unpacker
  import expr_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [EXPR_Y_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic [4:0]          out_idx,
  output logic                out_last
);

`ifdef EXPR_UNPACK_CHECKSUM_EN
  localparam logic [4:0] LAST_IDX = 5'd18;
`else
  localparam logic [4:0] LAST_IDX = 5'd17;
`endif

  expr_state_t         state;
  logic [EXPR_Y_W-1:0] hold;
  logic [4:0]          idx;
  logic [OUT_W-1:0]    field;

  expr_field_extract #(
    .OUT_W (OUT_W)
  ) u_extract (
    .hold (hold),
    .idx  (idx),
    .ext  (field)
  );

  assign out_idx = idx;

`ifdef EXPR_UNPACK_CHECKSUM_EN
  logic [OUT_W-1:0] acc;

  // Cleared on acceptance, accumulates each field as it is handshaken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (state == ST_IDLE && in_valid && in_ready) begin
      acc <= '0;
    end else if (state == ST_EMIT && out_ready && idx != LAST_IDX) begin
      acc <= acc + field;
    end
  end

  assign out_data = (idx == LAST_IDX) ? acc : field;
`else
  assign out_data = field;
`endif

  // out_data follows hold/idx, both registers, so it is stable while stalled
  // and returns to zero as soon as rst clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      hold      <= '0;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            hold      <= in_data;
            idx       <= '0;
            state     <= ST_EMIT;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (idx == LAST_IDX) begin
              state     <= ST_IDLE;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              idx      <= idx + 5'd1;
              out_last <= (idx + 5'd1 == LAST_IDX);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
